// File: rtl/ula_pkg.sv
// Shared types for the ALU result stage: op encoding, result record and op classification.
package ula_pkg;

    localparam int unsigned ULA_WIDTH = 32;
    localparam int unsigned ULA_TAG_W = 4;

    typedef enum logic [1:0] {
        ULA_ADD = 2'b00,
        ULA_SUB = 2'b01,
        ULA_AND = 2'b10,
        ULA_OR  = 2'b11
    } ula_op_t;

    typedef struct packed {
        logic [ULA_WIDTH-1:0] result;
        logic                 zero;
        logic                 overflow;
        ula_op_t              op;
        logic [ULA_TAG_W-1:0] tag;
    } ula_res_t;

    function automatic logic is_arith(input ula_op_t op);
        return (op == ULA_ADD) || (op == ULA_SUB);
    endfunction

endpackage

// File: rtl/ula_res_fifo.sv
// Generic DEPTH-entry FIFO storage with wrapping pointers, occupancy count and full/empty flags.
module ula_res_fifo #(
    parameter int unsigned DW    = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ula_result_stage.sv
// Registered result buffer after the ALU: FIFO handshake, masked outputs, overflow statistics.
// Optional overflow trap (entry dropped, trap pulse) enabled by defining ULA_OVF_TRAP_EN.
module ula_result_stage
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_result,
    input  logic                   in_zero,
    input  logic                   in_overflow,
    input  logic [1:0]             in_controle,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_result,
    output logic                   out_zero,
    output logic                   out_overflow,
    output logic [1:0]             out_controle,
    output logic [TAG_W-1:0]       out_tag,
    output logic [$clog2(DEPTH):0] count,
    input  logic                   clr_stats,
    output logic [CNT_W-1:0]       ovf_count,
    output logic                   ovf_sticky,
    output logic                   trap,
    output logic [TAG_W-1:0]       trap_tag
);

    localparam int unsigned DW = WIDTH + 4 + TAG_W;

    logic          push, pop, ovf_event, fifo_push;
    logic          full, empty;
    logic [DW-1:0] wdata, rdata;

    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
    logic             ovf_sticky_q, ovf_sticky_d;

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign ovf_event = push & in_overflow & is_arith(ula_op_t'(in_controle));

    // Same field order as ula_res_t, but sized from this instance's parameters.
    assign wdata = {in_result, in_zero, in_overflow, in_controle, in_tag};

    ula_res_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        {out_result, out_zero, out_overflow, out_controle, out_tag} = '0;
        if (!empty) {out_result, out_zero, out_overflow, out_controle, out_tag} = rdata;
    end

    always_comb begin
        ovf_count_d  = ovf_count_q;
        ovf_sticky_d = ovf_sticky_q;
        if (clr_stats) begin
            ovf_count_d  = '0;
            ovf_sticky_d = 1'b0;
        end else if (ovf_event) begin
            ovf_sticky_d = 1'b1;
            if (ovf_count_q != '1) ovf_count_d = ovf_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_count_q  <= '0;
            ovf_sticky_q <= 1'b0;
        end else begin
            ovf_count_q  <= ovf_count_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign ovf_count  = ovf_count_q;
    assign ovf_sticky = ovf_sticky_q;

`ifdef ULA_OVF_TRAP_EN
    logic             trap_q, trap_d;
    logic [TAG_W-1:0] trap_tag_q, trap_tag_d;

    assign fifo_push = push & ~ovf_event;

    always_comb begin
        trap_d     = ovf_event;
        trap_tag_d = ovf_event ? in_tag : trap_tag_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trap_q     <= 1'b0;
            trap_tag_q <= '0;
        end else begin
            trap_q     <= trap_d;
            trap_tag_q <= trap_tag_d;
        end
    end

    assign trap     = trap_q;
    assign trap_tag = trap_tag_q;
`else
    assign fifo_push = push;
    assign trap      = 1'b0;
    assign trap_tag  = '0;
`endif

endmodule

// File: tb/tb_ula_result_stage.sv
// Directed plus randomized checks of ula_result_stage against a queue-based reference model.
module tb_ula_result_stage;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ULA_OVF_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready, in_zero, in_overflow;
    logic [WIDTH-1:0] in_result;
    logic [1:0]       in_controle;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid, out_ready, out_zero, out_overflow;
    logic [WIDTH-1:0] out_result;
    logic [1:0]       out_controle;
    logic [TAG_W-1:0] out_tag;
    logic [$clog2(DEPTH):0] count;
    logic             clr_stats;
    logic [CNT_W-1:0] ovf_count;
    logic             ovf_sticky, trap;
    logic [TAG_W-1:0] trap_tag;

    ula_result_stage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_zero      (in_zero),
        .in_overflow  (in_overflow),
        .in_controle  (in_controle),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_controle (out_controle),
        .out_tag      (out_tag),
        .count        (count),
        .clr_stats    (clr_stats),
        .ovf_count    (ovf_count),
        .ovf_sticky   (ovf_sticky),
        .trap         (trap),
        .trap_tag     (trap_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        o;
        logic [1:0]  c;
        logic [3:0]  t;
    } ent_t;

    ent_t        mq[$];
    int          m_cnt = 0;
    bit          m_sticky = 1'b0;
    bit          m_trap = 1'b0;
    logic [3:0]  m_trap_tag = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_all();
        ent_t h;
        h = '{res: '0, z: 1'b0, o: 1'b0, c: '0, t: '0};
        if (mq.size() != 0) h = mq[0];
        chk("out_valid",    64'(out_valid),    64'(mq.size() != 0));
        chk("in_ready",     64'(in_ready),     64'(mq.size() != DEPTH));
        chk("count",        64'(count),        64'(mq.size()));
        chk("out_result",   64'(out_result),   64'(h.res));
        chk("out_zero",     64'(out_zero),     64'(h.z));
        chk("out_overflow", 64'(out_overflow), 64'(h.o));
        chk("out_controle", 64'(out_controle), 64'(h.c));
        chk("out_tag",      64'(out_tag),      64'(h.t));
        chk("ovf_count",    64'(ovf_count),    64'(m_cnt));
        chk("ovf_sticky",   64'(ovf_sticky),   64'(m_sticky));
        chk("trap",         64'(trap),         64'(m_trap));
        chk("trap_tag",     64'(trap_tag),     64'(m_trap_tag));
    endtask

    // One clock: drive inputs, advance the reference model, then compare after the edge.
    task automatic step(input bit v, input logic [31:0] r, input bit z, input bit o,
                        input logic [1:0] c, input logic [3:0] t, input bit ordy, input bit clr);
        bit acc, pp, ev;
        @(negedge clk);
        in_valid = v; in_result = r; in_zero = z; in_overflow = o;
        in_controle = c; in_tag = t; out_ready = ordy; clr_stats = clr;
        acc = v && (mq.size() != DEPTH);
        pp  = (mq.size() != 0) && ordy;
        ev  = acc && o && (c == 2'b00 || c == 2'b01);
        if (pp) void'(mq.pop_front());
        if (acc && !(TRAP_EN && ev)) mq.push_back('{res: r, z: z, o: o, c: c, t: t});
        if (clr) begin
            m_cnt = 0;
            m_sticky = 1'b0;
        end else if (ev) begin
            m_sticky = 1'b1;
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end
        m_trap = TRAP_EN && ev;
        if (m_trap) m_trap_tag = t;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, '0, 1'b0, 1'b0, 2'b10, '0, ordy, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_result = '0; in_zero = 1'b0; in_overflow = 1'b0;
        in_controle = '0; in_tag = '0; out_ready = 1'b0; clr_stats = 1'b0;
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Fill and drain
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'(3 + 2 * i), 1'b0, 1'b0, 2'b10, 4'(i), 1'b0, 1'b0);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        step(1'b1, 32'hB, 1'b0, 1'b0, 2'b10, 4'd4, 1'b0, 1'b0);
        chk("full_held_count", 64'(count), 64'd4);
        chk("head_tag0", 64'(out_tag), 64'd0);
        chk("head_res0", 64'(out_result), 64'h3);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            if (i < 3) chk("drain_tag", 64'(out_tag), 64'(i + 1));
        end
        chk("drained_valid", 64'(out_valid), 64'd0);
        chk("drained_result", 64'(out_result), 64'd0);

        // Pointer wrap with simultaneous push and pop
        step(1'b1, 32'h10, 1'b0, 1'b0, 2'b11, 4'd0, 1'b0, 1'b0);
        step(1'b1, 32'h11, 1'b1, 1'b0, 2'b11, 4'd1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'(32'h12 + i), 1'b0, 1'b0, 2'b11, 4'(i + 2), 1'b1, 1'b0);
            chk("wrap_count", 64'(count), 64'd2);
            chk("wrap_head_tag", 64'(out_tag), 64'(i + 1));
        end
        idle(1'b1);
        idle(1'b1);

        // Statistics
        step(1'b1, 32'h8000_0000, 1'b0, 1'b1, 2'b00, 4'd1, 1'b1, 1'b0);
        chk("stat_add_cnt", 64'(ovf_count), 64'd1);
        chk("stat_add_sticky", 64'(ovf_sticky), 64'd1);
        step(1'b1, 32'h0, 1'b1, 1'b1, 2'b10, 4'd2, 1'b1, 1'b0);
        chk("stat_and_cnt", 64'(ovf_count), 64'd1);
        step(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 2'b01, 4'd3, 1'b1, 1'b1);
        chk("stat_clr_cnt", 64'(ovf_count), 64'd0);
        chk("stat_clr_sticky", 64'(ovf_sticky), 64'd0);
        idle(1'b1);
        idle(1'b1);

        // Saturation at all-ones
        for (int i = 0; i < 17; i++)
            step(1'b1, 32'(i), 1'b0, 1'b1, 2'(i % 2), 4'(i), 1'b1, 1'b0);
        chk("sat_cnt", 64'(ovf_count), 64'hF);
        idle(1'b1);
        idle(1'b1);

        // Trap behaviour (or plain enqueue when the trap is not built)
        step(1'b1, 32'h8000_0001, 1'b0, 1'b1, 2'b01, 4'd5, 1'b0, 1'b0);
        chk("trap_count", 64'(count), TRAP_EN ? 64'd0 : 64'd1);
        chk("trap_pulse", 64'(trap), TRAP_EN ? 64'd1 : 64'd0);
        chk("trap_tag5", 64'(trap_tag), TRAP_EN ? 64'd5 : 64'd0);
        idle(1'b0);
        chk("trap_done", 64'(trap), 64'd0);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 1'($urandom),
                 2'($urandom), 4'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0));

        // Asynchronous reset mid-stream with three entries held
        step(1'b1, 32'hA1, 1'b0, 1'b0, 2'b10, 4'd1, 1'b1, 1'b0);
        while (mq.size() != 0) idle(1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'(32'hC0 + i), 1'b0, 1'b0, 2'b11, 4'(i), 1'b0, 1'b0);
        chk("pre_reset_count", 64'(count), 64'd3);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        mq.delete();
        m_cnt = 0; m_sticky = 1'b0; m_trap = 1'b0; m_trap_tag = '0;
        check_all();
        #1;
        reset = 1'b0;
        idle(1'b1);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'b00, 4'd9, 1'b0, 1'b0);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
